ctrl_flush_reg: RTL and testbench

Parametrised pipeline control-field register placed between decode and execute (ID/EX control path). It captures the WB/EX/MEM control groups each cycle, holds them on stall, and squashes them to a bubble on flush. A single flush request can inject a programmable number of consecutive bubbles, for example after a mispredicted branch in a deeper pipeline. This replaces purely combinational squashing with a registered, stall-aware stage that carries a valid bit.

---
 rtl/ctrl_flush_reg.sv | 83 ++++++++
 tb/tb_ctrl_flush_reg.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ctrl_flush_reg.sv
// ID/EX control-field register: loads, holds on stall, squashes to multi-cycle flush bubbles.
// Latency 1 cycle; stall_i holds the stage; bubbles advance even while stalled.
// Optional flush-bubble statistics counter is enabled by CTRL_FLUSH_REG_BUBBLE_CNT_EN.
module ctrl_flush_reg #(
  parameter int WB_W         = 2,
  parameter int EX_W         = 3,
  parameter int MEM_W        = 2,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WB_W-1:0]  WB_i,
  input  logic [EX_W-1:0]  EX_i,
  input  logic [MEM_W-1:0] MEM_i,
  input  logic             valid_i,
  input  logic             stall_i,
  input  logic             flush_i,
  output logic [WB_W-1:0]  WB_o,
  output logic [EX_W-1:0]  EX_o,
  output logic [MEM_W-1:0] MEM_o,
  output logic             valid_o,
  output logic             flushing_o
`ifdef CTRL_FLUSH_REG_BUBBLE_CNT_EN
  ,
  input  logic             cnt_clr_i,
  output logic [CNT_W-1:0] bubble_cnt_o
`endif
);

  localparam int FL_W = $clog2(FLUSH_CYCLES + 1);
  // The flush edge itself is the first bubble, so the counter only tracks the extra ones.
  localparam logic [FL_W-1:0] FL_RELOAD = FL_W'(FLUSH_CYCLES - 1);

  logic [FL_W-1:0] fl_cnt;
  logic            fl_active;
  logic            bubble;

  assign fl_active  = (fl_cnt != '0);
  assign bubble     = flush_i | fl_active;
  assign flushing_o = fl_active;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      WB_o    <= '0;
      EX_o    <= '0;
      MEM_o   <= '0;
      valid_o <= 1'b0;
      fl_cnt  <= '0;
    end else if (flush_i) begin
      WB_o    <= '0;
      EX_o    <= '0;
      MEM_o   <= '0;
      valid_o <= 1'b0;
      fl_cnt  <= FL_RELOAD;
    end else if (fl_active) begin
      WB_o    <= '0;
      EX_o    <= '0;
      MEM_o   <= '0;
      valid_o <= 1'b0;
      fl_cnt  <= fl_cnt - FL_W'(1);
    end else if (!stall_i) begin
      WB_o    <= WB_i;
      EX_o    <= EX_i;
      MEM_o   <= MEM_i;
      valid_o <= valid_i;
    end
  end

`ifdef CTRL_FLUSH_REG_BUBBLE_CNT_EN
  // Saturating count of written bubbles; a clear beats a same-edge increment.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      bubble_cnt_o <= '0;
    end else if (cnt_clr_i) begin
      bubble_cnt_o <= '0;
    end else if (bubble && (bubble_cnt_o != '1)) begin
      bubble_cnt_o <= bubble_cnt_o + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_ctrl_flush_reg.sv
// Directed table-driven bench for ctrl_flush_reg (FLUSH_CYCLES=3 main instance, default instance alongside).
module tb_ctrl_flush_reg;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic [1:0] WB_i  = '0;
  logic [2:0] EX_i  = '0;
  logic [1:0] MEM_i = '0;
  logic       valid_i = 1'b0;
  logic       stall_i = 1'b0;
  logic       flush_i = 1'b0;
  logic       cnt_clr_i = 1'b0;

  logic [1:0] WB_o, WB1_o;
  logic [2:0] EX_o, EX1_o;
  logic [1:0] MEM_o, MEM1_o;
  logic       valid_o, valid1_o, flushing_o, flushing1_o;
`ifdef CTRL_FLUSH_REG_BUBBLE_CNT_EN
  logic [1:0] bubble_cnt_o;
  logic [7:0] bubble_cnt1_o;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  ctrl_flush_reg #(.WB_W(2), .EX_W(3), .MEM_W(2), .FLUSH_CYCLES(3), .CNT_W(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .WB_i(WB_i), .EX_i(EX_i), .MEM_i(MEM_i),
    .valid_i(valid_i), .stall_i(stall_i), .flush_i(flush_i),
    .WB_o(WB_o), .EX_o(EX_o), .MEM_o(MEM_o), .valid_o(valid_o), .flushing_o(flushing_o)
`ifdef CTRL_FLUSH_REG_BUBBLE_CNT_EN
    , .cnt_clr_i(cnt_clr_i), .bubble_cnt_o(bubble_cnt_o)
`endif
  );

  ctrl_flush_reg dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .WB_i(WB_i), .EX_i(EX_i), .MEM_i(MEM_i),
    .valid_i(valid_i), .stall_i(stall_i), .flush_i(flush_i),
    .WB_o(WB1_o), .EX_o(EX1_o), .MEM_o(MEM1_o), .valid_o(valid1_o), .flushing_o(flushing1_o)
`ifdef CTRL_FLUSH_REG_BUBBLE_CNT_EN
    , .cnt_clr_i(cnt_clr_i), .bubble_cnt_o(bubble_cnt1_o)
`endif
  );

  typedef struct {
    logic [1:0] wb;   logic [2:0] ex;   logic [1:0] mem;
    logic vld, stl, fl, clr;
    logic [1:0] e_wb; logic [2:0] e_ex; logic [1:0] e_mem;
    logic e_vld, e_fl;
    logic [1:0] e_cnt;
  } vec_t;

  vec_t tbl[21];

  function automatic vec_t mk(input logic [1:0] wb, input logic [2:0] ex, input logic [1:0] mem,
                              input logic vld, input logic stl, input logic fl, input logic clr,
                              input logic [1:0] e_wb, input logic [2:0] e_ex, input logic [1:0] e_mem,
                              input logic e_vld, input logic e_fl, input logic [1:0] e_cnt);
    vec_t v;
    v.wb = wb; v.ex = ex; v.mem = mem; v.vld = vld; v.stl = stl; v.fl = fl; v.clr = clr;
    v.e_wb = e_wb; v.e_ex = e_ex; v.e_mem = e_mem; v.e_vld = e_vld; v.e_fl = e_fl; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] wb, input logic [2:0] ex, input logic [1:0] mem,
                       input logic vld, input logic stl, input logic fl, input logic clr);
    WB_i = wb; EX_i = ex; MEM_i = mem; valid_i = vld; stall_i = stl; flush_i = fl; cnt_clr_i = clr;
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    tbl[0]  = mk(2'd2, 3'd5, 2'd1, 1, 0, 0, 0,  2'd2, 3'd5, 2'd1, 1, 0, 2'd0);
    tbl[1]  = mk(2'd1, 3'd3, 2'd2, 1, 0, 0, 0,  2'd1, 3'd3, 2'd2, 1, 0, 2'd0);
    tbl[2]  = mk(2'd3, 3'd7, 2'd3, 0, 1, 0, 0,  2'd1, 3'd3, 2'd2, 1, 0, 2'd0);
    tbl[3]  = mk(2'd3, 3'd7, 2'd3, 0, 1, 0, 0,  2'd1, 3'd3, 2'd2, 1, 0, 2'd0);
    tbl[4]  = mk(2'd3, 3'd7, 2'd3, 0, 1, 0, 0,  2'd1, 3'd3, 2'd2, 1, 0, 2'd0);
    tbl[5]  = mk(2'd3, 3'd7, 2'd3, 1, 0, 0, 0,  2'd3, 3'd7, 2'd3, 1, 0, 2'd0);
    tbl[6]  = mk(2'd2, 3'd5, 2'd1, 1, 0, 1, 0,  2'd0, 3'd0, 2'd0, 0, 1, 2'd1);
    tbl[7]  = mk(2'd2, 3'd5, 2'd1, 1, 0, 0, 0,  2'd0, 3'd0, 2'd0, 0, 1, 2'd2);
    tbl[8]  = mk(2'd2, 3'd5, 2'd1, 1, 0, 0, 0,  2'd0, 3'd0, 2'd0, 0, 0, 2'd3);
    tbl[9]  = mk(2'd2, 3'd5, 2'd1, 1, 0, 0, 0,  2'd2, 3'd5, 2'd1, 1, 0, 2'd3);
    tbl[10] = mk(2'd1, 3'd2, 2'd3, 1, 1, 1, 0,  2'd0, 3'd0, 2'd0, 0, 1, 2'd3);
    tbl[11] = mk(2'd1, 3'd2, 2'd3, 1, 1, 0, 0,  2'd0, 3'd0, 2'd0, 0, 1, 2'd3);
    tbl[12] = mk(2'd1, 3'd2, 2'd3, 1, 0, 1, 0,  2'd0, 3'd0, 2'd0, 0, 1, 2'd3);
    tbl[13] = mk(2'd1, 3'd2, 2'd3, 1, 0, 0, 0,  2'd0, 3'd0, 2'd0, 0, 1, 2'd3);
    tbl[14] = mk(2'd1, 3'd2, 2'd3, 1, 0, 0, 0,  2'd0, 3'd0, 2'd0, 0, 0, 2'd3);
    tbl[15] = mk(2'd1, 3'd2, 2'd3, 1, 0, 0, 0,  2'd1, 3'd2, 2'd3, 1, 0, 2'd3);
    tbl[16] = mk(2'd1, 3'd2, 2'd3, 1, 0, 1, 1,  2'd0, 3'd0, 2'd0, 0, 1, 2'd0);
    tbl[17] = mk(2'd1, 3'd2, 2'd3, 1, 0, 0, 0,  2'd0, 3'd0, 2'd0, 0, 1, 2'd1);
    tbl[18] = mk(2'd1, 3'd2, 2'd3, 1, 0, 0, 1,  2'd0, 3'd0, 2'd0, 0, 0, 2'd0);
    tbl[19] = mk(2'd0, 3'd4, 2'd0, 0, 0, 0, 0,  2'd0, 3'd4, 2'd0, 0, 0, 2'd0);
    tbl[20] = mk(2'd3, 3'd3, 2'd3, 1, 1, 0, 0,  2'd0, 3'd4, 2'd0, 0, 0, 2'd0);

    // Reset held with random inputs: everything stays zero, asynchronously.
    rst_i = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      drive(2'($urandom), 3'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      tick();
      chk($sformatf("rst_hold%0d_ctl", i), {WB_o, EX_o, MEM_o, valid_o}, 32'd0);
      chk($sformatf("rst_hold%0d_fl", i), {flushing_o, flushing1_o, valid1_o}, 32'd0);
    end
    drive(2'd0, 3'd0, 2'd0, 0, 0, 0, 0);
    rst_i = 1'b1;
    #1;
    chk("rst_release_ctl", {WB_o, EX_o, MEM_o, valid_o, flushing_o}, 32'd0);
`ifdef CTRL_FLUSH_REG_BUBBLE_CNT_EN
    chk("rst_release_cnt", 32'(bubble_cnt_o), 32'd0);
`endif

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].wb, tbl[i].ex, tbl[i].mem, tbl[i].vld, tbl[i].stl, tbl[i].fl, tbl[i].clr);
      tick();
      chk($sformatf("v%0d_wb", i),  32'(WB_o),  32'(tbl[i].e_wb));
      chk($sformatf("v%0d_ex", i),  32'(EX_o),  32'(tbl[i].e_ex));
      chk($sformatf("v%0d_mem", i), 32'(MEM_o), 32'(tbl[i].e_mem));
      chk($sformatf("v%0d_vld", i), 32'(valid_o), 32'(tbl[i].e_vld));
      chk($sformatf("v%0d_flushing", i), 32'(flushing_o), 32'(tbl[i].e_fl));
`ifdef CTRL_FLUSH_REG_BUBBLE_CNT_EN
      chk($sformatf("v%0d_cnt", i), 32'(bubble_cnt_o), 32'(tbl[i].e_cnt));
`endif
    end

    // Single-bubble instance: one squash edge, flushing never asserts.
    drive(2'd2, 3'd5, 2'd1, 1, 0, 1, 0);
    tick();
    chk("fc1_flush_ctl", {WB1_o, EX1_o, MEM1_o, valid1_o}, 32'd0);
    chk("fc1_flush_flushing", 32'(flushing1_o), 32'd0);
    drive(2'd1, 3'd2, 2'd3, 1, 0, 0, 0);
    tick();
    chk("fc1_after_ctl", {WB1_o, EX1_o, MEM1_o, valid1_o}, {23'd0, 2'd1, 3'd2, 2'd3, 1'b1});
    chk("fc1_after_flushing", 32'(flushing1_o), 32'd0);
    chk("fc3_still_bubble", {valid_o, flushing_o}, 32'b01);

    // Reset in the middle of a multi-cycle flush.
    drive(2'd1, 3'd2, 2'd3, 1, 0, 1, 0);
    tick();
    chk("midrst_pre_flushing", 32'(flushing_o), 32'd1);
    drive(2'd1, 3'd2, 2'd3, 1, 0, 0, 0);
    rst_i = 1'b0;
    #1;
    chk("midrst_async_flushing", 32'(flushing_o), 32'd0);
    chk("midrst_async_ctl", {WB_o, EX_o, MEM_o, valid_o}, 32'd0);
`ifdef CTRL_FLUSH_REG_BUBBLE_CNT_EN
    chk("midrst_async_cnt", 32'(bubble_cnt_o), 32'd0);
`endif
    tick();
    chk("midrst_hold_ctl", {WB_o, EX_o, MEM_o, valid_o, flushing_o}, 32'd0);
    rst_i = 1'b1;
    drive(2'd2, 3'd5, 2'd1, 1, 0, 0, 0);
    tick();
    chk("midrst_reload_ctl", {WB_o, EX_o, MEM_o, valid_o}, {24'd0, 2'd2, 3'd5, 2'd1, 1'b1});
    chk("midrst_reload_flushing", 32'(flushing_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
